vmul_cpa_pipe: RTL and testbench
================================

// Module: vmul_cpa_pipe
// PURPOSE
//  Final carry-propagate stage of the vector multiplier. It consumes the redundant
//  sum/carry vectors from the full-adder CSA reduction tree and resolves them into one
//  binary product. The add is split into two registered halves (low, then high + carry-in)
//  so timing is met at the core clock. Ready/valid on both sides; one result per cycle.
// PARAMETERS
//  WIDTH  64  bit width of sum/carry/result vectors; must be even and >= 4
//  TAG_W  8   width of sideband tag (warp id / lane / dest reg) carried alongside data
// PORTS
//  clk          in   1       core clock, all state on rising edge
//  rst          in   1       synchronous reset, active-high
//  flush        in   1       synchronous kill of all in-flight entries
//  in_valid     in   1       sum/carry/tag valid
//  in_ready     out  1       stage 1 can accept this cycle
//  in_sum       in   WIDTH   CSA sum vector
//  in_carry     in   WIDTH   CSA carry vector, already aligned (shifted left 1 by tree)
//  in_tag       in   TAG_W   sideband, passed through unmodified
//  out_valid    out  1       result valid
//  out_ready    in   1       consumer accepts result
//  out_result   out  WIDTH   (in_sum + in_carry) mod 2^WIDTH
//  out_cout     out  1       carry out of bit WIDTH-1
//  out_tag      out  TAG_W   tag matching out_result
//  busy         out  1       s1_valid | s2_valid
// BEHAVIOUR
//  H = WIDTH/2. Two pipeline registers, S1 and S2, each holding a valid bit plus data.
//  Stage 1 (capture on in_valid & in_ready):
//   {s1_c, s1_lo} <= in_sum[H-1:0] + in_carry[H-1:0]   (H+1-bit add)
//   s1_sum_hi <= in_sum[WIDTH-1:H]; s1_car_hi <= in_carry[WIDTH-1:H]; s1_tag <= in_tag
//  Stage 2 (capture when s1_valid & s2_ready):
//   {s2_cout, s2_hi} <= s1_sum_hi + s1_car_hi + s1_c; s2_lo <= s1_lo; s2_tag <= s1_tag
//  Outputs are driven from S2 registers only: out_result = {s2_hi, s2_lo}, out_cout = s2_cout.
//  Handshake:
//   s2_ready = ~s2_valid | out_ready;  in_ready = ~s1_valid | s2_ready  (combinational,
//   no path from in_valid to in_ready). Full throughput 1/cycle when out_ready stays high.
//  Latency: an accepted input appears on out_* exactly 2 cycles later if never stalled.
//  Stall: with out_ready=0 and S2 full, S2 holds. S1 fills once, then in_ready=0.
//   out_* and out_valid are stable while out_valid & ~out_ready.
//  Valid updates each cycle:
//   s2_valid <= (s2_valid & ~out_ready) | (s1_valid & s2_ready)
//   s1_valid <= (s1_valid & ~s2_ready) | (in_valid & in_ready)
//  Simultaneous: a pop at S2, a shift S1->S2 and a push into S1 may all happen in one cycle.
//  flush=1: s1_valid, s2_valid <= 0 next cycle. An input presented the same cycle is
//   dropped. in_ready is not gated by flush. Data registers are left unchanged.
//  rst=1 (any time, including mid-operation): all valids 0. All data registers
//   (s1_*, s2_*) are 0. So out_valid=0, out_result=0, out_cout=0, out_tag=0, busy=0,
//   in_ready=1 the cycle after reset is released. rst has priority over flush.
//  Wrap-around: result is modulo 2^WIDTH and overflow is reported only in out_cout.
//   Signed interpretation is the consumer's responsibility.
//  A low-half carry (s1_c) must propagate into bit H of the high half, including the
//   case where the whole high half is all ones.
// TESTING (WIDTH=64, TAG_W=8)
//  1) sum=0x0000_0000_FFFF_FFFF, carry=0x1, tag=0x5A, out_ready=1 -> 2 cycles later
//     out_valid=1, result=0x0000_0001_0000_0000, cout=0, tag=0x5A
//  2) sum=0xFFFF_FFFF_FFFF_FFFF, carry=0x1 -> result=0, cout=1; also
//     sum=0x8000_0000_0000_0000, carry=0x8000_0000_0000_0000 -> result=0, cout=1
//  3) out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0 on C. Hold 5
//     cycles: out_result stays A. out_ready=1 -> A,B,C emerge on 3 consecutive cycles
//  4) 100 random back-to-back inputs, out_ready=1 -> 100 outputs in order, no bubbles,
//     each equals the reference model sum+carry (65-bit), tags match
//  5) 2 entries in flight, flush=1 for 1 cycle with in_valid=1 -> no out_valid
//     afterwards, busy=0 next cycle, the entry presented during flush is lost
//  6) rst asserted with S1 and S2 full and out_ready=0 -> next cycle out_valid=0,
//     out_result=0, out_tag=0, in_ready=1, busy=0

Source files
------------

// File: rtl/vmul_cpa_pipe.sv
// Final carry-propagate adder for the vector multiplier: resolves CSA sum/carry
// vectors into a binary product over two registered half-width stages.
module vmul_cpa_pipe #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int H = WIDTH / 2;

   // Half-width add with carry-in; the MSB of the return value is the carry out.
   function automatic logic [H:0] add_half(input logic [H-1:0] a,
                                           input logic [H-1:0] b,
                                           input logic         cin);
      return {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};
   endfunction

   logic             vld_p1;
   logic [H-1:0]     lo_p1;
   logic             c_p1;
   logic [H-1:0]     sum_hi_p1;
   logic [H-1:0]     car_hi_p1;
   logic [TAG_W-1:0] tag_p1;

   logic             vld_p2;
   logic [H-1:0]     lo_p2;
   logic [H-1:0]     hi_p2;
   logic             cout_p2;
   logic [TAG_W-1:0] tag_p2;

   logic             s2_ready;
   logic             push;
   logic             shift;
   logic [H:0]       lo_sum;
   logic [H:0]       hi_sum;

   assign s2_ready = ~vld_p2 | out_ready;
   assign in_ready = ~vld_p1 | s2_ready;
   assign push     = in_valid & in_ready;
   assign shift    = vld_p1 & s2_ready;

   assign lo_sum = add_half(in_sum[H-1:0], in_carry[H-1:0], 1'b0);
   assign hi_sum = add_half(sum_hi_p1, car_hi_p1, c_p1);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         lo_p1     <= '0;
         c_p1      <= 1'b0;
         sum_hi_p1 <= '0;
         car_hi_p1 <= '0;
         tag_p1    <= '0;
         vld_p2    <= 1'b0;
         lo_p2     <= '0;
         hi_p2     <= '0;
         cout_p2   <= 1'b0;
         tag_p2    <= '0;
      end else begin
         if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
         end else begin
            vld_p1 <= (vld_p1 & ~s2_ready) | push;
            vld_p2 <= (vld_p2 & ~out_ready) | shift;
         end

         // Stage 1: low half resolved, high half operands parked for stage 2.
         // A flush leaves the data registers untouched.
         if (push && !flush) begin
            {c_p1, lo_p1} <= lo_sum;
            sum_hi_p1     <= in_sum[WIDTH-1:H];
            car_hi_p1     <= in_carry[WIDTH-1:H];
            tag_p1        <= in_tag;
         end

         // Stage 2: high half absorbs the low-half carry.
         if (shift && !flush) begin
            {cout_p2, hi_p2} <= hi_sum;
            lo_p2            <= lo_p1;
            tag_p2           <= tag_p1;
         end
      end
   end

   assign out_valid  = vld_p2;
   assign out_result = {hi_p2, lo_p2};
   assign out_cout   = cout_p2;
   assign out_tag    = tag_p2;
   assign busy       = vld_p1 | vld_p2;

endmodule

// File: tb/tb_vmul_cpa_pipe.sv
// Directed bench for vmul_cpa_pipe (WIDTH=64, TAG_W=8) with hand-computed vectors.
module tb_vmul_cpa_pipe;

   localparam int WIDTH = 64;
   localparam int TAG_W = 8;
   localparam int NRND  = 100;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic [WIDTH-1:0] in_carry;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [WIDTH-1:0] r_sum   [NRND];
   logic [WIDTH-1:0] r_car   [NRND];
   logic [TAG_W-1:0] r_tag   [NRND];
   logic [WIDTH:0]   r_exp   [NRND];

   vmul_cpa_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_carry   (in_carry),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_tag    (out_tag),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      in_tag   = t;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_sum = '0; in_carry = '0; in_tag = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result",    out_result,     64'd0);
      chk("rst_cout",      64'(out_cout),  64'd0);
      chk("rst_tag",       64'(out_tag),   64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);

      // Low-half carry rippling into bit 32
      drive(64'h0000_0000_FFFF_FFFF, 64'h1, 8'h5A);
      tick();
      in_valid = 1'b0;
      chk("t1_lat1_valid", 64'(out_valid), 64'd0);
      chk("t1_lat1_busy",  64'(busy),      64'd1);
      tick();
      chk("t1_valid",  64'(out_valid), 64'd1);
      chk("t1_result", out_result,     64'h0000_0001_0000_0000);
      chk("t1_cout",   64'(out_cout),  64'd0);
      chk("t1_tag",    64'(out_tag),   64'h5A);

      // Wrap-around through an all-ones high half, and MSB overflow
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h11);
      tick();
      drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'h22);
      tick();
      in_valid = 1'b0;
      chk("t2a_valid",  64'(out_valid), 64'd1);
      chk("t2a_result", out_result,     64'd0);
      chk("t2a_cout",   64'(out_cout),  64'd1);
      chk("t2a_tag",    64'(out_tag),   64'h11);
      tick();
      chk("t2b_valid",  64'(out_valid), 64'd1);
      chk("t2b_result", out_result,     64'd0);
      chk("t2b_cout",   64'(out_cout),  64'd1);
      chk("t2b_tag",    64'(out_tag),   64'h22);
      tick();
      chk("t2_drain",   64'(out_valid), 64'd0);

      // Backpressure: A and B accepted, C refused until out_ready returns
      out_ready = 1'b0;
      drive(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 8'hA0);
      chk("t3_rdy_a", 64'(in_ready), 64'd1);
      tick();
      drive(64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 8'hB0);
      chk("t3_rdy_b", 64'(in_ready), 64'd1);
      tick();
      drive(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 8'hC0);
      chk("t3_rdy_c", 64'(in_ready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_valid",  64'(out_valid), 64'd1);
         chk("t3_hold_result", out_result,     64'h3333_3333_3333_3333);
         chk("t3_hold_rdy",    64'(in_ready),  64'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_rdy_release", 64'(in_ready), 64'd1);
      chk("t3_a_tag",       64'(out_tag),  64'hA0);
      tick();
      in_valid = 1'b0;
      chk("t3_b_valid",  64'(out_valid), 64'd1);
      chk("t3_b_result", out_result,     64'h0000_0001_0000_0000);
      chk("t3_b_cout",   64'(out_cout),  64'd0);
      chk("t3_b_tag",    64'(out_tag),   64'hB0);
      tick();
      chk("t3_c_valid",  64'(out_valid), 64'd1);
      chk("t3_c_result", out_result,     64'd0);
      chk("t3_c_cout",   64'(out_cout),  64'd1);
      chk("t3_c_tag",    64'(out_tag),   64'hC0);
      tick();
      chk("t3_drain",    64'(out_valid), 64'd0);

      // Random back-to-back stream checked against a 65-bit reference add
      for (int i = 0; i < NRND; i++) begin
         r_sum[i] = {$urandom(), $urandom()};
         r_car[i] = {$urandom(), $urandom()};
         r_tag[i] = TAG_W'($urandom());
         r_exp[i] = {1'b0, r_sum[i]} + {1'b0, r_car[i]};
      end
      for (int i = 0; i < NRND + 2; i++) begin
         if (i >= 2) begin
            chk("t4_valid",  64'(out_valid), 64'd1);
            chk("t4_result", out_result,     r_exp[i-2][WIDTH-1:0]);
            chk("t4_cout",   64'(out_cout),  64'(r_exp[i-2][WIDTH]));
            chk("t4_tag",    64'(out_tag),   64'(r_tag[i-2]));
         end
         if (i < NRND) drive(r_sum[i], r_car[i], r_tag[i]);
         else          in_valid = 1'b0;
         if (i < NRND) chk("t4_in_ready", 64'(in_ready), 64'd1);
         tick();
      end
      chk("t4_drain", 64'(out_valid), 64'd0);

      // Flush with two entries in flight and a third presented
      drive(64'h5, 64'h6, 8'hE1);
      tick();
      drive(64'h7, 64'h8, 8'hE2);
      tick();
      drive(64'h9, 64'hA, 8'hE3);
      flush = 1'b1;
      chk("t5_rdy_flush", 64'(in_ready), 64'd1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("t5_valid",  64'(out_valid), 64'd0);
      chk("t5_busy",   64'(busy),      64'd0);
      chk("t5_data",   out_result,     64'hB);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_lost", 64'(out_valid), 64'd0);
      end

      // Reset mid-operation with both stages full and stalled
      out_ready = 1'b0;
      drive(64'h1234, 64'h4321, 8'hF1);
      tick();
      drive(64'hABCD, 64'h1111, 8'hF2);
      tick();
      in_valid = 1'b0;
      chk("t6_pre_busy",  64'(busy),      64'd1);
      chk("t6_pre_rdy",   64'(in_ready),  64'd0);
      chk("t6_pre_res",   out_result,     64'h5555);
      rst = 1'b1;
      tick();
      chk("t6_valid",  64'(out_valid), 64'd0);
      chk("t6_result", out_result,     64'd0);
      chk("t6_cout",   64'(out_cout),  64'd0);
      chk("t6_tag",    64'(out_tag),   64'd0);
      chk("t6_rdy",    64'(in_ready),  64'd1);
      chk("t6_busy",   64'(busy),      64'd0);
      rst = 1'b0;
      tick();
      chk("t6_post_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
